// File: rtl/priority_arbiter_pkg_v.sv
// Shared definitions for the registered priority arbiter: FSM state encoding
// and a constant log2 helper used to size the grant index.
package priority_arbiter_pkg_v;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Ceiling log2, evaluated at elaboration time for port sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/priority_sel_v.sv
// Combinational rotating selector: scans vec from ptr downward with wrap
// (ptr, ptr-1, ..., 0, N-1, ..., ptr+1) and reports the first set bit.
module priority_sel_v
    import priority_arbiter_pkg_v::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         hit
);

    int         start_idx;
    int         cand;
    logic [W-1:0] cand_w;
    logic [W-1:0] win;

    always_comb begin
        // An out-of-range pointer can only arise for non-power-of-two N; clamp it.
        start_idx = (int'(ptr) < N) ? int'(ptr) : N - 1;
        hit       = 1'b0;
        win       = '0;
        cand      = 0;
        cand_w    = '0;
        for (int i = 0; i < N; i++) begin
            cand   = (start_idx >= i) ? (start_idx - i) : (start_idx + N - i);
            cand_w = W'(cand);
            if (!hit && vec[cand_w]) begin
                hit = 1'b1;
                win = cand_w;
            end
        end
        idx    = win;
        onehot = hit ? (N'(1) << win) : '0;
    end

endmodule

// File: rtl/priority_arbiter_v.sv
// Registered priority arbiter with hold/advance handshake. Define
// PRIORITY_ARBITER_RR_EN for rotating priority; otherwise highest index wins.
module priority_arbiter_v
    import priority_arbiter_pkg_v::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_code,
    input  logic         i_advance,
    output logic [W-1:0] o_code,
    output logic [N-1:0] o_onehot,
    output logic         o_valid
);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] code_nxt;
    logic [N-1:0] onehot_nxt;

    logic [N-1:0] sel_vec;
    logic [W-1:0] sel_ptr;
    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_onehot;
    logic         sel_hit;

    logic advance_take;
    logic withdrawn;

    // Advance wins over a simultaneous withdrawal of the granted bit.
    assign advance_take = (state == ST_GRANT) && i_advance;
    assign withdrawn    = (state == ST_GRANT) && !i_advance && !(|(i_code & o_onehot));

    // On advance the just-served source is masked out of the re-selection.
    assign sel_vec = advance_take ? (i_code & ~o_onehot) : i_code;

`ifdef PRIORITY_ARBITER_RR_EN
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_dec;

    // Modulo-N decrement; the 0 -> N-1 wrap must not rely on power-of-two N.
    assign ptr_dec = (o_code == '0) ? W'(N - 1) : (o_code - W'(1));
    assign sel_ptr = advance_take ? ptr_dec : ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr <= W'(N - 1);
        end else begin
            ptr <= sel_ptr;
        end
    end
`else
    assign sel_ptr = W'(N - 1);
`endif

    priority_sel_v #(
        .N (N)
    ) u_sel (
        .vec    (sel_vec),
        .ptr    (sel_ptr),
        .idx    (sel_idx),
        .onehot (sel_onehot),
        .hit    (sel_hit)
    );

    always_comb begin
        state_nxt  = state;
        code_nxt   = o_code;
        onehot_nxt = o_onehot;
        case (state)
            ST_IDLE: begin
                if (sel_hit) begin
                    state_nxt  = ST_GRANT;
                    code_nxt   = sel_idx;
                    onehot_nxt = sel_onehot;
                end
            end
            ST_GRANT: begin
                // A held request keeps its grant even if higher priorities arrive.
                if (advance_take || withdrawn) begin
                    if (sel_hit) begin
                        code_nxt   = sel_idx;
                        onehot_nxt = sel_onehot;
                    end else begin
                        state_nxt  = ST_IDLE;
                        code_nxt   = '0;
                        onehot_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                code_nxt   = '0;
                onehot_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            o_code   <= '0;
            o_onehot <= '0;
        end else begin
            state    <= state_nxt;
            o_code   <= code_nxt;
            o_onehot <= onehot_nxt;
        end
    end

    assign o_valid = (state == ST_GRANT);

endmodule

// File: tb/tb_priority_arbiter_v.sv
// Directed bench for priority_arbiter_v (N=8 and N=5 instances); expectations
// follow PRIORITY_ARBITER_RR_EN when it is defined for the build.
module tb_priority_arbiter_v;

    logic       clk;
    logic       rst;

    logic [7:0] code8;
    logic       adv8;
    logic [2:0] o_code8;
    logic [7:0] o_onehot8;
    logic       o_valid8;

    logic [4:0] code5;
    logic       adv5;
    logic [2:0] o_code5;
    logic [4:0] o_onehot5;
    logic       o_valid5;

    int errors;
    int checks;

    priority_arbiter_v #(.N(8)) dut8 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_code    (code8),
        .i_advance (adv8),
        .o_code    (o_code8),
        .o_onehot  (o_onehot8),
        .o_valid   (o_valid8)
    );

    priority_arbiter_v #(.N(5)) dut5 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_code    (code5),
        .i_advance (adv5),
        .o_code    (o_code5),
        .o_onehot  (o_onehot5),
        .o_valid   (o_valid5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        code8 = 8'h00; adv8 = 1'b0; code5 = 5'h00; adv5 = 1'b0;
        do_reset();
        checks++;
        if ({o_valid8, o_code8, o_onehot8} !== {1'b0, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL reset8: valid=%0b code=%0d onehot=%h expected 0 0 00", o_valid8, o_code8, o_onehot8);
        end
        checks++;
        if ({o_valid5, o_code5, o_onehot5} !== {1'b0, 3'd0, 5'h00}) begin
            errors++;
            $display("FAIL reset5: valid=%0b code=%0d onehot=%h expected 0 0 00", o_valid5, o_code5, o_onehot5);
        end
        // advance while idle must leave the pointer alone
        adv8 = 1'b1;
        cyc();
        checks++;
        if (o_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_advance_valid: valid=%0b expected 0", o_valid8);
        end
        adv8 = 1'b0; code8 = 8'h81;
        cyc();
        checks++;
        if ({o_valid8, o_code8, o_onehot8} !== {1'b1, 3'd7, 8'h80}) begin
            errors++;
            $display("FAIL idle_advance_ptr: valid=%0b code=%0d onehot=%h expected 1 7 80", o_valid8, o_code8, o_onehot8);
        end
        code8 = 8'h00;
    endtask

    task automatic test_sweep();
        logic       ev;
        logic [2:0] ec;
        logic [7:0] eo;
        for (int v = 0; v < 256; v++) begin
            do_reset();
            code8 = 8'(v); adv8 = 1'b0;
            cyc();
            ev = 1'b0; ec = 3'd0; eo = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (v[b]) begin
                    ev = 1'b1; ec = 3'(b); eo = 8'h01 << b;
                end
            end
            checks++;
            if ({o_valid8, o_code8, o_onehot8} !== {ev, ec, eo}) begin
                errors++;
                $display("FAIL sweep_%02h: valid=%0b code=%0d onehot=%h expected %0b %0d %h",
                         v, o_valid8, o_code8, o_onehot8, ev, ec, eo);
            end
        end
        code8 = 8'h00;
    endtask

    task automatic test_hold();
        do_reset();
        code8 = 8'h10; adv8 = 1'b0;
        cyc();
        checks++;
        if ({o_valid8, o_code8} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL hold_first: valid=%0b code=%0d expected 1 4", o_valid8, o_code8);
        end
        code8 = 8'h90;
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++;
            if ({o_valid8, o_code8, o_onehot8} !== {1'b1, 3'd4, 8'h10}) begin
                errors++;
                $display("FAIL hold_keep%0d: code=%0d onehot=%h expected 4 10", k, o_code8, o_onehot8);
            end
        end
        adv8 = 1'b1;
        cyc();
        adv8 = 1'b0;
        checks++;
        if ({o_valid8, o_code8, o_onehot8} !== {1'b1, 3'd7, 8'h80}) begin
            errors++;
            $display("FAIL hold_next: code=%0d onehot=%h expected 7 80", o_code8, o_onehot8);
        end
        code8 = 8'h00;
    endtask

    task automatic test_back_to_back();
        int exp8 [9];
`ifdef PRIORITY_ARBITER_RR_EN
        exp8 = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
        exp8 = '{7, 6, 7, 6, 7, 6, 7, 6, 7};
`endif
        do_reset();
        code8 = 8'hFF; adv8 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            checks++;
            if ({o_valid8, o_code8, o_onehot8} !== {1'b1, 3'(exp8[k]), 8'h01 << exp8[k]}) begin
                errors++;
                $display("FAIL b2b_%0d: valid=%0b code=%0d onehot=%h expected 1 %0d", k, o_valid8, o_code8, o_onehot8, exp8[k]);
            end
        end
        adv8 = 1'b0; code8 = 8'h00;
    endtask

    task automatic test_withdraw();
        do_reset();
        code8 = 8'h08; adv8 = 1'b0;
        cyc();
        checks++;
        if (o_code8 !== 3'd3) begin
            errors++;
            $display("FAIL withdraw_grant: code=%0d expected 3", o_code8);
        end
        code8 = 8'h01;
        cyc();
        checks++;
        if ({o_valid8, o_code8, o_onehot8} !== {1'b1, 3'd0, 8'h01}) begin
            errors++;
            $display("FAIL withdraw_regrant: valid=%0b code=%0d onehot=%h expected 1 0 01", o_valid8, o_code8, o_onehot8);
        end
        code8 = 8'h00;
        cyc();
        checks++;
        if ({o_valid8, o_onehot8} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL withdraw_release: valid=%0b onehot=%h expected 0 00", o_valid8, o_onehot8);
        end
        // pointer untouched by withdrawal: 8'h81 still resolves to 7
        code8 = 8'h81;
        cyc();
        checks++;
        if ({o_valid8, o_code8} !== {1'b1, 3'd7}) begin
            errors++;
            $display("FAIL withdraw_ptr: valid=%0b code=%0d expected 1 7", o_valid8, o_code8);
        end
        code8 = 8'h00;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        code8 = 8'hFF; adv8 = 1'b1;
        cyc(); cyc(); cyc();
        adv8 = 1'b0;
        checks++;
        if (o_valid8 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: valid=%0b expected 1", o_valid8);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_valid8, o_code8, o_onehot8} !== {1'b0, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL midrst_async: valid=%0b code=%0d onehot=%h expected 0 0 00", o_valid8, o_code8, o_onehot8);
        end
        #1;
        rst = 1'b0;
        code8 = 8'h01;
        cyc();
        checks++;
        if ({o_valid8, o_code8} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL midrst_first: valid=%0b code=%0d expected 1 0", o_valid8, o_code8);
        end
        code8 = 8'h00;
        cyc();
        code8 = 8'hFF;
        cyc();
        checks++;
        if (o_code8 !== 3'd7) begin
            errors++;
            $display("FAIL midrst_ptr: code=%0d expected 7", o_code8);
        end
        adv8 = 1'b1;
        cyc();
        adv8 = 1'b0;
        checks++;
        if (o_code8 !== 3'd6) begin
            errors++;
            $display("FAIL midrst_next: code=%0d expected 6", o_code8);
        end
        code8 = 8'h00;
    endtask

    task automatic test_non_pow2();
        int exp5 [6];
`ifdef PRIORITY_ARBITER_RR_EN
        exp5 = '{4, 3, 2, 1, 0, 4};
`else
        exp5 = '{4, 3, 4, 3, 4, 3};
`endif
        do_reset();
        code5 = 5'h1F; adv5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            checks++;
            if ({o_valid5, o_code5, o_onehot5} !== {1'b1, 3'(exp5[k]), 5'h01 << exp5[k]}) begin
                errors++;
                $display("FAIL n5_%0d: valid=%0b code=%0d onehot=%h expected 1 %0d", k, o_valid5, o_code5, o_onehot5, exp5[k]);
            end
        end
        adv5 = 1'b0; code5 = 5'h00;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        code8 = 8'h00; adv8 = 1'b0;
        code5 = 5'h00; adv5 = 1'b0;
        #1;
        test_reset();
        test_sweep();
        test_hold();
        test_back_to_back();
        test_withdraw();
        test_reset_mid_grant();
        test_non_pow2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_arbiter_v.md
# priority_arbiter_v

Parametrised, registered successor to the 8-to-3 priority encoder. It accepts an N-bit request vector and registers a grant as a binary index plus a one-hot vector. The grant is held until the consumer pulses `i_advance`. Selection is either fixed priority, where the highest index wins, or rotating (round-robin) priority. The block sits in the datapath wherever several sources compete for one shared resource.

## Interface
- `N`, default 8: number of request lines; legal range 2..32, not required to be a power of two.
- `W`, default `$clog2(N)`: index width. Local, derived, not overridable.
- `i_clk`  in  1  rising-edge clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_code`  in  N  request vector; bit k high = source k requesting.
- `i_advance`  in  1  consumer accepts the current grant; sampled only when `o_valid`=1.
- `o_code`  out  W  registered index of the granted source.
- `o_onehot`  out  N  registered one-hot of the grant; equals `1<<o_code` when valid, else 0.
- `o_valid`  out  1  a grant is held.

## Operation
- FSM states:
  - IDLE: `o_valid`=0.
  - GRANT: `o_valid`=1.
- Selector `sel(vec, ptr)` scans from index `ptr` downward: ptr, ptr-1, …, 0, N-1, …, ptr+1. It returns the first set bit, or none.
- Fixed mode: `ptr` is constant N-1, so the highest set index wins (the classic priority encoder).
- IDLE:
  - if `|i_code`: register `sel(i_code, ptr)` and go to GRANT.
  - otherwise stay in IDLE.
- GRANT with `i_advance`=1 (grant consumed):
  - rotating mode: `ptr` ← `(o_code-1) mod N`, so the just-served source becomes lowest priority.
  - then re-select from `i_code & ~o_onehot` using the new `ptr`.
  - a hit registers the new grant and stays in GRANT (back-to-back grants); no hit goes to IDLE.
- GRANT with `i_advance`=0 and `i_code[o_code]`=0 (request withdrawn):
  - re-select from `i_code` with the unchanged `ptr`.
  - a hit registers the new grant; no hit goes to IDLE.
  - `ptr` is not updated.
- GRANT with `i_advance`=0 and the request still high: hold `o_code`/`o_onehot` unchanged, even if higher-priority requests appear.
- `i_advance` in IDLE: ignored, with no `ptr` change.
- Index arithmetic is modulo N. The wrap from 0 to N-1 must be correct for non-power-of-two N.

## Timing
- Reset values: `o_code`=0, `o_onehot`=0, `o_valid`=0, state=IDLE, `ptr`=N-1. Reset applies immediately and asynchronously, including mid-grant. The first edge after deassertion evaluates as IDLE.
- Latency: a request sampled at edge t gives `o_valid`/`o_code` after edge t, i.e. one cycle.
- Throughput: one grant per cycle when `i_advance` is held high and other requests remain.
- Withdraw to release or re-grant: one cycle.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.
- Simultaneous advance and withdrawal of the granted bit: the advance rule applies.

## Configuration
- `PRIORITY_ARBITER_RR_EN`:
  - defined: rotating priority as above.
  - undefined: the `ptr` register is not built, `ptr` is tied to N-1, and the block is pure fixed-priority with hold/advance semantics.
- Reset values and handshake are identical in both builds.

## Structure
- Shared package `priority_arbiter_pkg_v`:
  - state encoding constants `ST_IDLE`=1'b0, `ST_GRANT`=1'b1.
  - a constant `clog2` function for sizing W.
- One sub-module, `priority_sel_v`: combinational rotating selector with parameter N, inputs `vec[N-1:0]` and `ptr[W-1:0]`, outputs `idx[W-1:0]`, `onehot[N-1:0]`, `hit`. It is instantiated once. In the fixed build its `ptr` is tied to N-1.

## Test plan
- Sweep all 256 values of `i_code` with `i_advance`=0, reset between patterns (N=8, either build): `o_code` = index of highest set bit one cycle later. `i_code`=0 keeps `o_valid`=0.
- Hold: grant 8'h10, then raise 8'h90 without advance → `o_code` stays 4 until advance. The next grant is 7.
- Round-robin (RR build, N=8): `i_code`=8'hFF, `i_advance`=1 every cycle → `o_code` sequence 7,6,5,4,3,2,1,0,7. In the fixed build, `i_code`=8'hFF with advance → 7 then 6 repeatedly, since 7 is excluded only on its advance cycle.
- Withdraw: grant 8'h08 (code 3), drop bit 3 with `i_code`=8'h01 → next cycle `o_code`=0 with no `ptr` change. Drop to 0 → `o_valid`=0.
- Reset mid-grant: assert `i_rst` between edges while `o_valid`=1 → outputs 0 immediately. After release, `i_code`=8'h01 → `o_code`=0. RR sequence restarts from `ptr`=7.
- Non-power-of-two N=5, RR build: `i_code`=5'h1F with continuous advance → 4,3,2,1,0,4. `o_code` never exceeds 4.
